csr_unit: RTL and testbench



---
 rtl/riscv_defines.sv | 42 ++++
 rtl/csr_counter64.sv | 35 +++
 rtl/csr_unit.sv | 176 +++++++++++++++++
 tb/tb_csr_unit.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defines.sv
// Shared machine-mode CSR definitions: addresses, access encodings and field layout.
package riscv_defines;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  // Counter windows: addr[11:5] selects low (0xB00..) or high (0xB80..) halves.
  localparam logic [6:0] CNT_LO_WIN = 7'h58;
  localparam logic [6:0] CNT_HI_WIN = 7'h5C;

  typedef enum logic [1:0] {
    CsrNone = 2'b00,
    CsrRw   = 2'b01,
    CsrRs   = 2'b10,
    CsrRc   = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    MtvecDirect   = 2'b00,
    MtvecVectored = 2'b01
  } mtvec_mode_e;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;

  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;
  localparam logic [31:0] MIE_MASK   = 32'h0000_0888;

  // Counter k lives at address index 0 (mcycle), 2 (minstret), then 3.. for hpm.
  function automatic logic [4:0] cnt_index(input int unsigned k);
    return (k == 0) ? 5'd0 : 5'(k + 1);
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter whose halves can be loaded independently; a load suppresses counting.
module csr_counter64 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] value_o
);

  logic [63:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i) begin
      cnt_d[31:0] = wdata_i;
    end else if (wr_hi_i) begin
      cnt_d[63:32] = wdata_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o = cnt_q;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: CSR access channel, trap/MRET sequencing, counters and irq pending.
module csr_unit
  import riscv_defines::*;
#(
  parameter int unsigned NUM_HPM     = 2,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               csr_valid,
  input  logic [1:0]         csr_op,
  input  logic [11:0]        csr_addr,
  input  logic [31:0]        csr_wdata,
  output logic [31:0]        csr_rdata,
  output logic               csr_illegal,
  input  logic               trap_valid,
  input  logic [31:0]        trap_cause,
  input  logic [31:0]        trap_pc,
  input  logic [31:0]        trap_tval,
  input  logic               mret_valid,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc,
  input  logic               instret_inc,
  input  logic [NUM_HPM-1:0] hpm_event,
  input  logic               irq_ext,
  input  logic               irq_timer,
  input  logic               irq_sw,
  output logic               irq_pending
);

  localparam int unsigned NumCnt = 2 + NUM_HPM;

  logic        mstatus_mie_q, mstatus_mpie_q;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;

  logic [31:0] mstatus_rd, mip_rd, rd_value, wval, vec_base;
  logic        rd_known, wr_attempt, write_ok;
  csr_op_e     op;

  logic [63:0]       cnt_val [NumCnt];
  logic [NumCnt-1:0] cnt_wr_lo, cnt_wr_hi;

  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
  assign mip_rd     = {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_sw, 3'b0};

  always_comb begin
    rd_known = 1'b1;
    rd_value = '0;
    case (csr_addr)
      CSR_MSTATUS:  rd_value = mstatus_rd;
      CSR_MISA:     rd_value = MISA_VALUE;
      CSR_MIE:      rd_value = mie_q;
      CSR_MTVEC:    rd_value = mtvec_q;
      CSR_MSCRATCH: rd_value = mscratch_q;
      CSR_MEPC:     rd_value = mepc_q;
      CSR_MCAUSE:   rd_value = mcause_q;
      CSR_MTVAL:    rd_value = mtval_q;
      CSR_MIP:      rd_value = mip_rd;
      CSR_MHARTID:  rd_value = HART_ID;
      default: begin
        rd_known = 1'b0;
        for (int unsigned k = 0; k < NumCnt; k++) begin
          if ((csr_addr[11:5] == CNT_LO_WIN || csr_addr[11:5] == CNT_HI_WIN) &&
              csr_addr[4:0] == cnt_index(k)) begin
            rd_known = 1'b1;
            rd_value = csr_addr[7] ? cnt_val[k][63:32] : cnt_val[k][31:0];
          end
        end
      end
    endcase
  end

  assign op          = csr_op_e'(csr_op);
  assign wr_attempt  = (op == CsrRw) || ((op == CsrRs || op == CsrRc) && (csr_wdata != '0));
  assign csr_illegal = csr_valid && (!rd_known || (csr_addr[11:10] == 2'b11 && wr_attempt));
  assign csr_rdata   = csr_illegal ? '0 : rd_value;
  // Trap and MRET take the cycle; a coincident CSR write is dropped.
  assign write_ok    = csr_valid && !csr_illegal && wr_attempt && !trap_valid && !mret_valid;

  always_comb begin
    case (op)
      CsrRw:   wval = csr_wdata;
      CsrRs:   wval = rd_value | csr_wdata;
      CsrRc:   wval = rd_value & ~csr_wdata;
      default: wval = rd_value;
    endcase
  end

  always_comb begin
    cnt_wr_lo = '0;
    cnt_wr_hi = '0;
    for (int unsigned k = 0; k < NumCnt; k++) begin
      if (write_ok && csr_addr[4:0] == cnt_index(k)) begin
        cnt_wr_lo[k] = (csr_addr[11:5] == CNT_LO_WIN);
        cnt_wr_hi[k] = (csr_addr[11:5] == CNT_HI_WIN);
      end
    end
  end

  for (genvar k = 0; k < NumCnt; k++) begin : g_cnt
    logic inc;
    if (k == 0) begin : g_cycle
      assign inc = 1'b1;
    end else if (k == 1) begin : g_instret
      assign inc = instret_inc;
    end else begin : g_hpm
      assign inc = hpm_event[k-2];
    end
    csr_counter64 u_cnt (
      .clk_i   (clk),
      .rst_i   (rst),
      .inc_i   (inc),
      .wr_lo_i (cnt_wr_lo[k]),
      .wr_hi_i (cnt_wr_hi[k]),
      .wdata_i (wval),
      .value_o (cnt_val[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= MTVEC_RESET;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
    end else if (trap_valid) begin
      mepc_q         <= trap_pc & ~32'h3;
      mcause_q       <= trap_cause;
      mtval_q        <= trap_tval;
      mstatus_mpie_q <= mstatus_mie_q;
      mstatus_mie_q  <= 1'b0;
    end else if (mret_valid) begin
      mstatus_mie_q  <= mstatus_mpie_q;
      mstatus_mpie_q <= 1'b1;
    end else if (write_ok) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mstatus_mie_q  <= wval[MSTATUS_MIE_BIT];
          mstatus_mpie_q <= wval[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:      mie_q      <= wval & MIE_MASK;
        // Reserved modes 2/3 leave the current mode in place.
        CSR_MTVEC:    mtvec_q    <= {wval[31:2], (wval[1] ? mtvec_q[1:0] : wval[1:0])};
        CSR_MSCRATCH: mscratch_q <= wval;
        CSR_MEPC:     mepc_q     <= wval & ~32'h3;
        CSR_MCAUSE:   mcause_q   <= wval;
        CSR_MTVAL:    mtval_q    <= wval;
        default: ;
      endcase
    end
  end

  assign vec_base       = {mtvec_q[31:2], 2'b00};
  assign redirect_valid = trap_valid | mret_valid;

  always_comb begin
    redirect_pc = '0;
    if (trap_valid) begin
      if (mtvec_q[1:0] == MtvecVectored && trap_cause[31]) begin
        redirect_pc = vec_base + {25'b0, trap_cause[4:0], 2'b00};
      end else begin
        redirect_pc = vec_base;
      end
    end else if (mret_valid) begin
      redirect_pc = mepc_q;
    end
  end

  assign irq_pending = mstatus_mie_q & |(mie_q & mip_rd);

endmodule

// File: tb/tb_csr_unit.sv
// Bench for csr_unit: directed table, corner sequences and random traffic against a CSR model.
module tb_csr_unit;

  localparam int unsigned NHPM      = 2;
  localparam logic [31:0] MTVEC_RST = 32'h0000_0100;
  localparam logic [31:0] HARTID    = 32'd5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1, csr_valid = 1'b0, trap_valid = 1'b0, mret_valid = 1'b0;
  logic [1:0]      csr_op = '0;
  logic [11:0]     csr_addr = '0;
  logic [31:0]     csr_wdata = '0, trap_cause = '0, trap_pc = '0, trap_tval = '0;
  logic [31:0]     csr_rdata, redirect_pc;
  logic            csr_illegal, redirect_valid, irq_pending;
  logic            instret_inc = 1'b0, irq_ext = 1'b0, irq_timer = 1'b0, irq_sw = 1'b0;
  logic [NHPM-1:0] hpm_event = '0;

  csr_unit #(
    .NUM_HPM     (NHPM),
    .MTVEC_RESET (MTVEC_RST),
    .HART_ID     (HARTID)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .csr_valid      (csr_valid),
    .csr_op         (csr_op),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata),
    .csr_illegal    (csr_illegal),
    .trap_valid     (trap_valid),
    .trap_cause     (trap_cause),
    .trap_pc        (trap_pc),
    .trap_tval      (trap_tval),
    .mret_valid     (mret_valid),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instret_inc    (instret_inc),
    .hpm_event      (hpm_event),
    .irq_ext        (irq_ext),
    .irq_timer      (irq_timer),
    .irq_sw         (irq_sw),
    .irq_pending    (irq_pending)
  );

  typedef struct packed {
    logic        rst;
    logic        valid;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        tv;
    logic [31:0] cause;
    logic [31:0] tpc;
    logic [31:0] tval;
    logic        mv;
    logic        inc;
    logic [1:0]  ev;
    logic [2:0]  irq;  // {ext, timer, sw}
  } stim_t;

  typedef struct packed {
    stim_t       s;
    logic [31:0] rd;
    logic        ill;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Architectural model state.
  logic        m_mie, m_mpie;
  logic [31:0] m_miecsr, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cnt [2+NHPM];

  logic [31:0] act_rdata, act_pc;
  logic        act_ill, act_rv, act_irq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t acc(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
    stim_t s;
    s = '0;
    s.valid = 1'b1;
    s.op    = op;
    s.addr  = a;
    s.wdata = wd;
    return s;
  endfunction

  function automatic vec_t mk(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input logic ill);
    vec_t v;
    v.s   = acc(op, a, wd);
    v.rd  = rd;
    v.ill = ill;
    return v;
  endfunction

  function automatic logic [31:0] mip_of(input logic [2:0] irq);
    return (irq[2] ? 32'h800 : 32'h0) | (irq[1] ? 32'h80 : 32'h0) | (irq[0] ? 32'h8 : 32'h0);
  endfunction

  // Which modelled counter an address names, or -1.
  function automatic int cnt_of(input logic [11:0] a);
    int n;
    if (a[11:8] != 4'hB || a[6:5] != 2'b00) return -1;
    n = int'(a[4:0]);
    if (n == 0) return 0;
    if (n == 2) return 1;
    if (n >= 3 && n < 3 + int'(NHPM)) return n - 1;
    return -1;
  endfunction

  function automatic void model_read(input logic [11:0] a, input logic [2:0] irq,
                                     output logic ok, output logic [31:0] v);
    int c;
    ok = 1'b1;
    v  = '0;
    case (a)
      12'h300: v = 32'h1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
      12'h301: v = 32'h4000_0100;
      12'h304: v = m_miecsr;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344: v = mip_of(irq);
      12'hF14: v = HARTID;
      default: begin
        c = cnt_of(a);
        if (c < 0) ok = 1'b0;
        else v = a[7] ? m_cnt[c][63:32] : m_cnt[c][31:0];
      end
    endcase
  endfunction

  task automatic apply(input stim_t s);
    logic        ok, wa, ill, inc;
    logic [31:0] oldv, rd, pc, nv, base;
    int          wc;
    @(negedge clk);
    rst = s.rst; csr_valid = s.valid; csr_op = s.op; csr_addr = s.addr; csr_wdata = s.wdata;
    trap_valid = s.tv; trap_cause = s.cause; trap_pc = s.tpc; trap_tval = s.tval;
    mret_valid = s.mv; instret_inc = s.inc; hpm_event = s.ev;
    irq_ext = s.irq[2]; irq_timer = s.irq[1]; irq_sw = s.irq[0];
    #1;
    act_rdata = csr_rdata; act_ill = csr_illegal; act_rv = redirect_valid;
    act_pc = redirect_pc; act_irq = irq_pending;
    if (s.rst) begin
      m_mie = 0; m_mpie = 0; m_miecsr = 0; m_mtvec = MTVEC_RST; m_mscratch = 0;
      m_mepc = 0; m_mcause = 0; m_mtval = 0;
      for (int c = 0; c < 2 + int'(NHPM); c++) m_cnt[c] = 0;
    end else begin
      model_read(s.addr, s.irq, ok, oldv);
      wa  = (s.op == 2'd1) || (s.op != 2'd0 && s.wdata != 0);
      ill = s.valid && (!ok || (s.addr[11:10] == 2'b11 && wa));
      rd  = (ok && !ill) ? oldv : 32'h0;
      chk($sformatf("rdata[%h]", s.addr), act_rdata, rd);
      chk($sformatf("illegal[%h]", s.addr), 32'(act_ill), 32'(ill));
      chk("redirect_valid", 32'(act_rv), 32'(s.tv | s.mv));
      chk("irq_pending", 32'(act_irq), 32'(m_mie && ((m_miecsr & mip_of(s.irq)) != 0)));
      base = m_mtvec & ~32'h3;
      if (s.tv) pc = (m_mtvec[1:0] == 2'd1 && s.cause[31]) ? base + 4 * s.cause[4:0] : base;
      else pc = m_mepc;
      if (s.tv || s.mv) chk("redirect_pc", act_pc, pc);
      wc = -1;
      nv = '0;
      if (s.tv) begin
        m_mepc = s.tpc & ~32'h3; m_mcause = s.cause; m_mtval = s.tval;
        m_mpie = m_mie; m_mie = 0;
      end else if (s.mv) begin
        m_mie = m_mpie; m_mpie = 1;
      end else if (s.valid && !ill && wa) begin
        nv = (s.op == 2'd1) ? s.wdata : (s.op == 2'd2) ? (oldv | s.wdata) : (oldv & ~s.wdata);
        case (s.addr)
          12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
          12'h304: m_miecsr = nv & 32'h888;
          12'h305: m_mtvec = {nv[31:2], (nv[1:0] >= 2'd2) ? m_mtvec[1:0] : nv[1:0]};
          12'h340: m_mscratch = nv;
          12'h341: m_mepc = nv & ~32'h3;
          12'h342: m_mcause = nv;
          12'h343: m_mtval = nv;
          default: wc = cnt_of(s.addr);
        endcase
      end
      for (int c = 0; c < 2 + int'(NHPM); c++) begin
        inc = (c == 0) ? 1'b1 : (c == 1) ? s.inc : s.ev[c-2];
        if (c == wc) begin
          if (s.addr[7]) m_cnt[c][63:32] = nv;
          else m_cnt[c][31:0] = nv;
        end else if (inc) begin
          m_cnt[c] = m_cnt[c] + 64'd1;
        end
      end
    end
    @(posedge clk);
  endtask

  localparam logic [1:0] RW = 2'd1, RS = 2'd2, RC = 2'd3;
  localparam logic [11:0] AddrPool [23] = '{
    12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
    12'hB00, 12'hB02, 12'hB03, 12'hB04, 12'hB05, 12'hB80, 12'hB82, 12'hB83, 12'hB84,
    12'hB85, 12'hB01, 12'hF14, 12'h7C0, 12'hC00
  };

  initial begin
    stim_t s;
    vec_t  tbl [23];

    s = idle(); s.rst = 1'b1;
    apply(s);
    apply(s);
    apply(idle());
    chk("reset irq_pending", 32'(act_irq), 32'h0);
    chk("reset redirect_valid", 32'(act_rv), 32'h0);

    tbl[0]  = mk(RS, 12'h300, 32'h0,        32'h0000_1800, 1'b0);
    tbl[1]  = mk(RS, 12'h305, 32'h0,        MTVEC_RST,     1'b0);
    tbl[2]  = mk(RS, 12'hF14, 32'h0,        HARTID,        1'b0);
    tbl[3]  = mk(RS, 12'h301, 32'h0,        32'h4000_0100, 1'b0);
    tbl[4]  = mk(RW, 12'h340, 32'hDEAD_BEEF, 32'h0,        1'b0);
    tbl[5]  = mk(RC, 12'h340, 32'h0000_00FF, 32'hDEAD_BEEF, 1'b0);
    tbl[6]  = mk(RS, 12'h340, 32'h0,        32'hDEAD_BE00, 1'b0);
    tbl[7]  = mk(RW, 12'hF14, 32'h1,        32'h0,         1'b1);
    tbl[8]  = mk(RS, 12'hF14, 32'h0,        HARTID,        1'b0);
    tbl[9]  = mk(RS, 12'hB05, 32'h0,        32'h0,         1'b1);
    tbl[10] = mk(RS, 12'hB01, 32'h0,        32'h0,         1'b1);
    tbl[11] = mk(RW, 12'h341, 32'h1237,     32'h0,         1'b0);
    tbl[12] = mk(RS, 12'h341, 32'h0,        32'h1234,      1'b0);
    tbl[13] = mk(RW, 12'h305, 32'h0000_0203, MTVEC_RST,    1'b0);
    tbl[14] = mk(RS, 12'h305, 32'h0,        32'h0000_0200, 1'b0);
    tbl[15] = mk(RW, 12'h304, 32'hFFFF_FFFF, 32'h0,        1'b0);
    tbl[16] = mk(RS, 12'h304, 32'h0,        32'h0000_0888, 1'b0);
    tbl[17] = mk(RW, 12'h300, 32'hFFFF_FFFF, 32'h0000_1800, 1'b0);
    tbl[18] = mk(RS, 12'h300, 32'h0,        32'h0000_1888, 1'b0);
    tbl[19] = mk(RS, 12'h344, 32'h0,        32'h0,         1'b0);
    tbl[20] = mk(RW, 12'h344, 32'hFFFF_FFFF, 32'h0,        1'b0);
    tbl[21] = mk(RS, 12'h344, 32'h0,        32'h0,         1'b0);
    tbl[22] = mk(RS, 12'hC00, 32'h0,        32'h0,         1'b1);
    for (int i = 0; i < 23; i++) begin
      apply(tbl[i].s);
      chk($sformatf("tbl%0d rdata", i), act_rdata, tbl[i].rd);
      chk($sformatf("tbl%0d illegal", i), 32'(act_ill), 32'(tbl[i].ill));
    end

    // Vectored interrupt trap.
    apply(acc(RW, 12'h305, 32'h8000_0101));
    s = idle(); s.tv = 1; s.cause = 32'h8000_0007; s.tpc = 32'h0000_1003; s.tval = 32'hABCD;
    apply(s);
    chk("vec trap redirect_pc", act_pc, 32'h8000_011C);
    apply(acc(RS, 12'h341, 32'h0));
    chk("trap mepc", act_rdata, 32'h0000_1000);
    apply(acc(RS, 12'h300, 32'h0));
    chk("trap mstatus", act_rdata, 32'h0000_1880);
    apply(acc(RS, 12'h342, 32'h0));
    chk("trap mcause", act_rdata, 32'h8000_0007);

    // Exception in vectored mode goes to base; MPIE picks up MIE=0.
    apply(acc(RC, 12'h300, 32'h80));
    s = idle(); s.tv = 1; s.cause = 32'h2; s.tpc = 32'h2000;
    apply(s);
    chk("exc redirect_pc", act_pc, 32'h8000_0100);
    apply(acc(RS, 12'h300, 32'h0));
    chk("exc mstatus", act_rdata, 32'h0000_1800);

    // Interrupt pending, trap, then MRET restores MIE.
    s = acc(RS, 12'h300, 32'h8); s.irq = 3'b010;
    apply(s);
    chk("irq before MIE", 32'(act_irq), 32'h0);
    s = idle(); s.irq = 3'b010;
    apply(s);
    chk("irq pending", 32'(act_irq), 32'h1);
    s = idle(); s.irq = 3'b010; s.tv = 1; s.cause = 32'h8000_0007; s.tpc = 32'h3002;
    apply(s);
    chk("irq trap redirect_pc", act_pc, 32'h8000_011C);
    s = acc(RS, 12'h300, 32'h0); s.irq = 3'b010;
    apply(s);
    chk("irq masked in handler", 32'(act_irq), 32'h0);
    chk("handler mstatus", act_rdata, 32'h0000_1880);
    s = idle(); s.irq = 3'b010; s.mv = 1;
    apply(s);
    chk("mret redirect_pc", act_pc, 32'h0000_3000);
    s = acc(RS, 12'h300, 32'h0); s.irq = 3'b010;
    apply(s);
    chk("mret mstatus", act_rdata, 32'h0000_1888);
    chk("irq after mret", 32'(act_irq), 32'h1);

    // 64-bit wrap of minstret.
    apply(acc(RW, 12'hB02, 32'hFFFF_FFFF));
    apply(acc(RW, 12'hB82, 32'hFFFF_FFFF));
    s = idle(); s.inc = 1;
    apply(s);
    apply(acc(RS, 12'hB02, 32'h0));
    chk("minstret wrap lo", act_rdata, 32'h0);
    apply(acc(RS, 12'hB82, 32'h0));
    chk("minstret wrap hi", act_rdata, 32'h0);

    // Counter loads suppress that cycle's increment.
    apply(acc(RW, 12'hB80, 32'h1234_5678));
    apply(acc(RW, 12'hB00, 32'h0000_0100));
    apply(acc(RS, 12'hB00, 32'h0));
    chk("mcycle load", act_rdata, 32'h0000_0100);
    apply(acc(RS, 12'hB80, 32'h0));
    chk("mcycleh load", act_rdata, 32'h1234_5678);
    apply(acc(RS, 12'hB00, 32'h0));
    chk("mcycle counts", act_rdata, 32'h0000_0102);

    // Trap + MRET + write in one cycle: trap wins, write dropped.
    apply(acc(RW, 12'h340, 32'h1111));
    s = acc(RW, 12'h340, 32'h2222); s.tv = 1; s.mv = 1; s.cause = 32'h5; s.tpc = 32'h4000;
    apply(s);
    chk("collide redirect_pc", act_pc, 32'h8000_0100);
    apply(acc(RS, 12'h340, 32'h0));
    chk("collide mscratch", act_rdata, 32'h1111);

    // Reset beats a coincident trap.
    s = idle(); s.rst = 1; s.tv = 1; s.tpc = 32'h4444; s.cause = 32'h3;
    apply(s);
    apply(acc(RS, 12'h341, 32'h0));
    chk("reset vs trap mepc", act_rdata, 32'h0);
    apply(acc(RS, 12'h305, 32'h0));
    chk("reset mtvec", act_rdata, MTVEC_RST);

    for (int i = 0; i < 3000; i++) begin
      s       = idle();
      s.rst   = ($urandom_range(0, 199) == 0);
      s.valid = ($urandom_range(0, 3) != 0);
      s.op    = 2'($urandom_range(0, 3));
      s.addr  = AddrPool[$urandom_range(0, 22)];
      s.wdata = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      s.tv    = ($urandom_range(0, 7) == 0);
      s.mv    = ($urandom_range(0, 7) == 0);
      s.cause = {1'($urandom_range(0, 1)), 26'h0, 5'($urandom_range(0, 31))};
      s.tpc   = $urandom;
      s.tval  = $urandom;
      s.inc   = 1'($urandom_range(0, 1));
      s.ev    = 2'($urandom_range(0, 3));
      s.irq   = 3'($urandom_range(0, 7));
      apply(s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
